// File: rtl/snoop_responder.sv
// snoop_responder
// Per-PE cache-side agent sitting at the far end of the snoop controller's
// request and broadcast lines. A snoop request looks up the broadcast address
// in the local tag/data arrays. The result comes back as DATA_AVAILABLE or
// DATA_NOT_AVAILABLE, and the hit block is driven onto SNOOP_DATA_BUS. A
// broadcast from another PE that hits a local line writes that line.
//
// Build option:
//   SNOOP_INVALIDATE_EN  defined     -> write-invalidate (UPDATE_VALID=0, UPDATE_DATA=0)
//                        not defined -> write-update (UPDATE_VALID=1, UPDATE_DATA=broadcast block)
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-low reset
//   SNOOP_REQUEST         request pulse from the controller (rising edge detected)
//   BROADCAST_ADDR_BUS    address under snoop or broadcast
//   BROADCAST_DATA_BUS    broadcast block data
//   BROADCAST_INTERRUPT   new-data broadcast pulse (rising edge detected)
//   SELF_BROADCAST        this PE sourced the broadcast; sampled with its edge
//   DATA_AVAILABLE        level, last lookup hit
//   DATA_NOT_AVAILABLE    level, last lookup missed
//   SNOOP_DATA_BUS        block from the last hit
//   ARRAY_REQ/ARRAY_GRANT arbitration handshake for the cache arrays
//   ARRAY_INDEX           set index presented to the arrays
//   ARRAY_TAG/VALID/DATA  array read data, one cycle after ARRAY_INDEX
//   UPDATE_WRITE          one-cycle write strobe to the line at ARRAY_INDEX
//   UPDATE_VALID/DATA     valid bit and block written with UPDATE_WRITE
module snoop_responder #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int IDX_W  = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     SNOOP_REQUEST,
    input  logic [ADDR_W-1:0]        BROADCAST_ADDR_BUS,
    input  logic [DATA_W-1:0]        BROADCAST_DATA_BUS,
    input  logic                     BROADCAST_INTERRUPT,
    input  logic                     SELF_BROADCAST,
    output logic                     DATA_AVAILABLE,
    output logic                     DATA_NOT_AVAILABLE,
    output logic [DATA_W-1:0]        SNOOP_DATA_BUS,
    output logic                     ARRAY_REQ,
    input  logic                     ARRAY_GRANT,
    output logic [IDX_W-1:0]         ARRAY_INDEX,
    input  logic [ADDR_W-IDX_W-1:0]  ARRAY_TAG,
    input  logic                     ARRAY_VALID,
    input  logic [DATA_W-1:0]        ARRAY_DATA,
    output logic                     UPDATE_WRITE,
    output logic                     UPDATE_VALID,
    output logic [DATA_W-1:0]        UPDATE_DATA
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB_R, S_ARB_B, S_RD_R, S_RD_B, S_CMP_R, S_CMP_B, S_WR_B
    } state_t;

    state_t state_q, state_d;

    logic              req_p0, bc_p0;
    logic              req_rise, bc_rise;
    logic              req_pend, bc_pend;
    logic [ADDR_W-1:0] req_addr, bc_addr;
    logic [DATA_W-1:0] bc_data;
    logic              bc_self;

    // Operands frozen when the arrays are granted, so a re-armed request or a
    // newer broadcast cannot change the address between index and compare.
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              cur_self;
    logic              hit;

    assign req_rise = SNOOP_REQUEST & ~req_p0;
    assign bc_rise  = BROADCAST_INTERRUPT & ~bc_p0;
    assign hit      = ARRAY_VALID && (ARRAY_TAG == cur_addr[ADDR_W-1:IDX_W]);

    // Control state: FSM, edge detectors, pending flags, response registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q            <= S_IDLE;
            req_p0             <= 1'b0;
            bc_p0              <= 1'b0;
            req_pend           <= 1'b0;
            bc_pend            <= 1'b0;
            DATA_AVAILABLE     <= 1'b0;
            DATA_NOT_AVAILABLE <= 1'b0;
            SNOOP_DATA_BUS     <= '0;
        end else begin
            state_q <= state_d;
            req_p0  <= SNOOP_REQUEST;
            bc_p0   <= BROADCAST_INTERRUPT;

            // A fresh edge in the completing cycle wins over the clear.
            if (req_rise)
                req_pend <= 1'b1;
            else if (state_q == S_CMP_R)
                req_pend <= 1'b0;

            if (bc_rise)
                bc_pend <= 1'b1;
            else if (state_q == S_CMP_B)
                bc_pend <= 1'b0;

            if (state_q == S_CMP_R) begin
                DATA_AVAILABLE     <= hit;
                DATA_NOT_AVAILABLE <= ~hit;
                if (hit)
                    SNOOP_DATA_BUS <= ARRAY_DATA;
            end
        end
    end

    // Captured operands: qualified by edges and grant, no reset needed
    always_ff @(posedge CLK) begin
        if (req_rise)
            req_addr <= BROADCAST_ADDR_BUS;
        if (bc_rise) begin
            bc_addr <= BROADCAST_ADDR_BUS;
            bc_data <= BROADCAST_DATA_BUS;
            bc_self <= SELF_BROADCAST;
        end
        if (state_q == S_ARB_R && ARRAY_GRANT) begin
            cur_addr <= req_addr;
            cur_self <= 1'b0;
        end else if (state_q == S_ARB_B && ARRAY_GRANT) begin
            cur_addr <= bc_addr;
            cur_data <= bc_data;
            cur_self <= bc_self;
        end
    end

    // Next state and array-side outputs
    always_comb begin
        state_d      = state_q;
        ARRAY_REQ    = 1'b0;
        ARRAY_INDEX  = '0;
        UPDATE_WRITE = 1'b0;
        UPDATE_VALID = 1'b0;
        UPDATE_DATA  = '0;
        case (state_q)
            S_IDLE: begin
                // Looking at the raw edge too lets the edge cycle double as
                // the sync cycle; requests take priority over broadcasts.
                if (req_pend || req_rise)
                    state_d = S_ARB_R;
                else if (bc_pend || bc_rise)
                    state_d = S_ARB_B;
            end
            S_ARB_R: begin
                ARRAY_REQ = 1'b1;
                if (ARRAY_GRANT)
                    state_d = S_RD_R;
            end
            S_ARB_B: begin
                ARRAY_REQ = 1'b1;
                if (ARRAY_GRANT)
                    state_d = S_RD_B;
            end
            S_RD_R: begin
                ARRAY_REQ   = 1'b1;
                ARRAY_INDEX = cur_addr[IDX_W-1:0];
                state_d     = S_CMP_R;
            end
            S_RD_B: begin
                ARRAY_REQ   = 1'b1;
                ARRAY_INDEX = cur_addr[IDX_W-1:0];
                state_d     = S_CMP_B;
            end
            S_CMP_R: begin
                ARRAY_REQ = 1'b1;
                state_d   = S_IDLE;
            end
            S_CMP_B: begin
                ARRAY_REQ = 1'b1;
                state_d   = (hit && !cur_self) ? S_WR_B : S_IDLE;
            end
            S_WR_B: begin
                ARRAY_REQ    = 1'b1;
                ARRAY_INDEX  = cur_addr[IDX_W-1:0];
                UPDATE_WRITE = 1'b1;
`ifdef SNOOP_INVALIDATE_EN
                UPDATE_VALID = 1'b0;
                UPDATE_DATA  = '0;
`else
                UPDATE_VALID = 1'b1;
                UPDATE_DATA  = cur_data;
`endif
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: lookup hit/miss, broadcast update,
// self/miss broadcasts, request-vs-broadcast priority, grant stall and
// mid-operation reset, against a small registered cache-array model.
module tb_snoop_responder;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int IDX_W  = 3;
    localparam int TAG_W  = ADDR_W - IDX_W;

    localparam logic [ADDR_W-1:0] A1   = 28'h1234565;
    localparam logic [TAG_W-1:0]  TAG5 = TAG_W'(28'h1234567 >> 3);
    localparam logic [DATA_W-1:0] D    = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [DATA_W-1:0] BA5  = {16{8'hA5}};
    localparam logic [DATA_W-1:0] B5A  = {16{8'h5A}};
`ifdef SNOOP_INVALIDATE_EN
    localparam logic              EXP_VALID = 1'b0;
    localparam logic [DATA_W-1:0] EXP_D1    = '0;
    localparam logic [DATA_W-1:0] EXP_D2    = '0;
`else
    localparam logic              EXP_VALID = 1'b1;
    localparam logic [DATA_W-1:0] EXP_D1    = BA5;
    localparam logic [DATA_W-1:0] EXP_D2    = B5A;
`endif

    logic              CLK = 1'b0;
    logic              RESET;
    logic              SNOOP_REQUEST;
    logic [ADDR_W-1:0] BROADCAST_ADDR_BUS;
    logic [DATA_W-1:0] BROADCAST_DATA_BUS;
    logic              BROADCAST_INTERRUPT;
    logic              SELF_BROADCAST;
    logic              DATA_AVAILABLE;
    logic              DATA_NOT_AVAILABLE;
    logic [DATA_W-1:0] SNOOP_DATA_BUS;
    logic              ARRAY_REQ;
    logic              ARRAY_GRANT;
    logic [IDX_W-1:0]  ARRAY_INDEX;
    logic [TAG_W-1:0]  ARRAY_TAG;
    logic              ARRAY_VALID;
    logic [DATA_W-1:0] ARRAY_DATA;
    logic              UPDATE_WRITE;
    logic              UPDATE_VALID;
    logic [DATA_W-1:0] UPDATE_DATA;

    logic              grant_en;
    logic [TAG_W-1:0]  mem_tag   [8];
    logic              mem_valid [8];
    logic [DATA_W-1:0] mem_data  [8];

    int                wr_cnt = 0;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    snoop_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .SNOOP_REQUEST       (SNOOP_REQUEST),
        .BROADCAST_ADDR_BUS  (BROADCAST_ADDR_BUS),
        .BROADCAST_DATA_BUS  (BROADCAST_DATA_BUS),
        .BROADCAST_INTERRUPT (BROADCAST_INTERRUPT),
        .SELF_BROADCAST      (SELF_BROADCAST),
        .DATA_AVAILABLE      (DATA_AVAILABLE),
        .DATA_NOT_AVAILABLE  (DATA_NOT_AVAILABLE),
        .SNOOP_DATA_BUS      (SNOOP_DATA_BUS),
        .ARRAY_REQ           (ARRAY_REQ),
        .ARRAY_GRANT         (ARRAY_GRANT),
        .ARRAY_INDEX         (ARRAY_INDEX),
        .ARRAY_TAG           (ARRAY_TAG),
        .ARRAY_VALID         (ARRAY_VALID),
        .ARRAY_DATA          (ARRAY_DATA),
        .UPDATE_WRITE        (UPDATE_WRITE),
        .UPDATE_VALID        (UPDATE_VALID),
        .UPDATE_DATA         (UPDATE_DATA)
    );

    assign ARRAY_GRANT = ARRAY_REQ & grant_en;

    // Cache array model: registered read, one cycle after the index
    always @(posedge CLK) begin
        ARRAY_TAG   <= mem_tag[ARRAY_INDEX];
        ARRAY_VALID <= mem_valid[ARRAY_INDEX];
        ARRAY_DATA  <= mem_data[ARRAY_INDEX];
    end

    // Write-strobe monitor
    always @(posedge CLK) begin
        if (UPDATE_WRITE) begin
            wr_cnt   <= wr_cnt + 1;
            wr_idx   <= ARRAY_INDEX;
            wr_valid <= UPDATE_VALID;
            wr_data  <= UPDATE_DATA;
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_req(input logic [ADDR_W-1:0] addr);
        BROADCAST_ADDR_BUS = addr;
        SNOOP_REQUEST      = 1'b1;
        tick(1);
        SNOOP_REQUEST      = 1'b0;
    endtask

    task automatic pulse_bc(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data, input logic self_bc);
        BROADCAST_ADDR_BUS  = addr;
        BROADCAST_DATA_BUS  = data;
        SELF_BROADCAST      = self_bc;
        BROADCAST_INTERRUPT = 1'b1;
        tick(1);
        BROADCAST_INTERRUPT = 1'b0;
        SELF_BROADCAST      = 1'b0;
    endtask

    initial begin
        RESET               = 1'b0;
        SNOOP_REQUEST       = 1'b0;
        BROADCAST_INTERRUPT = 1'b0;
        SELF_BROADCAST      = 1'b0;
        BROADCAST_ADDR_BUS  = '0;
        BROADCAST_DATA_BUS  = '0;
        grant_en            = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_tag[i]   = '0;
            mem_valid[i] = 1'b0;
            mem_data[i]  = '0;
        end
        mem_tag[5]   = TAG5;
        mem_valid[5] = 1'b1;
        mem_data[5]  = D;

        // Reset state
        tick(3);
        chk("rst_flags", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE, ARRAY_REQ, UPDATE_WRITE}), 128'(0));
        chk("rst_bus", SNOOP_DATA_BUS, '0);
        RESET = 1'b1;
        tick(2);

        // 1: lookup hit on line 5, 4-cycle latency
        pulse_req(A1);
        chk("t1_arb_req", 128'(ARRAY_REQ), 128'(1));
        tick(1);
        chk("t1_rd_index", 128'(ARRAY_INDEX), 128'(5));
        tick(1);
        chk("t1_not_early", 128'(DATA_AVAILABLE), 128'(0));
        tick(1);
        chk("t1_avail", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE}), 128'(2'b10));
        chk("t1_bus", SNOOP_DATA_BUS, D);
        tick(1);
        chk("t1_req_drop", 128'(ARRAY_REQ), 128'(0));

        // 2: tag mismatch, then invalid line with matching tag
        pulse_req(A1 ^ 28'h400);
        tick(2);
        chk("t2_hold", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE}), 128'(2'b10));
        tick(1);
        chk("t2_tagmiss", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE}), 128'(2'b01));
        chk("t2_bus_kept", SNOOP_DATA_BUS, D);
        mem_valid[5] = 1'b0;
        pulse_req(A1);
        tick(3);
        chk("t2_invalid", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE}), 128'(2'b01));
        mem_valid[5] = 1'b1;
        tick(1);

        // 3: broadcast hit from another PE writes line 5 once
        pulse_bc(A1, BA5, 1'b0);
        tick(3);
        chk("t3_strobe", 128'(UPDATE_WRITE), 128'(1));
        chk("t3_wr_idx", 128'(ARRAY_INDEX), 128'(5));
        chk("t3_wr_valid", 128'(UPDATE_VALID), 128'(EXP_VALID));
        chk("t3_wr_data", UPDATE_DATA, EXP_D1);
        tick(1);
        chk("t3_strobe_off", 128'(UPDATE_WRITE), 128'(0));
        chk("t3_wr_cnt", 128'(wr_cnt), 128'(1));
        chk("t3_resp_kept", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE}), 128'(2'b01));

        // 4: self broadcast and broadcast miss leave the array alone
        pulse_bc(A1, B5A, 1'b1);
        tick(6);
        chk("t4_self", 128'(wr_cnt), 128'(1));
        pulse_bc(A1 ^ 28'h800, B5A, 1'b0);
        tick(6);
        chk("t4_miss", 128'(wr_cnt), 128'(1));

        // 5: simultaneous edges, request first then broadcast write
        BROADCAST_ADDR_BUS  = A1;
        BROADCAST_DATA_BUS  = B5A;
        SELF_BROADCAST      = 1'b0;
        SNOOP_REQUEST       = 1'b1;
        BROADCAST_INTERRUPT = 1'b1;
        tick(1);
        SNOOP_REQUEST       = 1'b0;
        BROADCAST_INTERRUPT = 1'b0;
        tick(2);
        chk("t5_early", 128'({DATA_AVAILABLE, wr_cnt == 1}), 128'(2'b01));
        tick(1);
        chk("t5_req_first", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE, wr_cnt == 1}), 128'(3'b101));
        tick(5);
        chk("t5_bc_cnt", 128'(wr_cnt), 128'(2));
        chk("t5_bc_idx", 128'(wr_idx), 128'(5));
        chk("t5_bc_valid", 128'(wr_valid), 128'(EXP_VALID));
        chk("t5_bc_data", wr_data, EXP_D2);

        // 5b: grant held low for 10 cycles stretches the response
        grant_en = 1'b0;
        pulse_req(A1 ^ 28'h400);
        for (int i = 0; i < 9; i++) begin
            chk("t5_stall", 128'({ARRAY_REQ, DATA_NOT_AVAILABLE, UPDATE_WRITE}), 128'(3'b100));
            tick(1);
        end
        grant_en = 1'b1;
        tick(2);
        chk("t5_stall_early", 128'(DATA_NOT_AVAILABLE), 128'(0));
        tick(1);
        chk("t5_stall_resp", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE}), 128'(2'b01));
        chk("t5_stall_nowr", 128'(wr_cnt), 128'(2));
        tick(1);

        // 6: reset while in RD_R
        pulse_req(A1);
        tick(1);
        chk("t6_in_rd", 128'({ARRAY_REQ, ARRAY_INDEX}), 128'({1'b1, 3'd5}));
        RESET = 1'b0;
        #1;
        chk("t6_rst_flags", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE, ARRAY_REQ, UPDATE_WRITE}), 128'(0));
        chk("t6_rst_index", 128'(ARRAY_INDEX), 128'(0));
        chk("t6_rst_bus", SNOOP_DATA_BUS, '0);
        tick(1);
        RESET = 1'b1;
        tick(8);
        chk("t6_no_resp", 128'({DATA_AVAILABLE, DATA_NOT_AVAILABLE, ARRAY_REQ}), 128'(0));
        chk("t6_no_wr", 128'(wr_cnt), 128'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
